mult_div_unit: RTL and testbench
================================

# mult_div_unit

Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers. It sits in the EX stage beside the ALU and executes MULT/MULTU/DIV/DIVU plus MTHI/MTLO writes. It exposes a `busy` flag; the hazard unit uses that flag to stall any later HI/LO access (MFHI/MFLO/MT*/MULT*/DIV*) until the result is committed. Latencies are parameters, so the stall logic can be exercised against realistic multi-cycle timing.

## Interface
- `WIDTH`, 32: operand and HI/LO width.
- `MULT_CYCLES`, 5: cycles `busy` stays high for MULT/MULTU; must be ≥1.
- `DIV_CYCLES`, 10: cycles `busy` stays high for DIV/DIVU; must be ≥1.

- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; clears all state.
- `A`  in  WIDTH  operand (rs value).
- `B`  in  WIDTH  operand (rt value).
- `op`  in  3  0 NONE, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as NONE).
- `start`  in  1  request qualifier; `op` is acted on only when `start`=1.
- `busy`  out  1  a mult/div is in flight.
- `HI`  out  WIDTH  HI register.
- `LO`  out  WIDTH  LO register.

## Operation
- Two states, IDLE and RUN, plus a down-counter sized to max(MULT_CYCLES, DIV_CYCLES).
- IDLE + `start` + op∈{MULT..DIVU}:
  - latch A, B and op;
  - load the counter with the op's latency;
  - go to RUN.
- IDLE + `start` + MTHI/MTLO: HI (resp. LO) ← A at that edge. State stays IDLE.
- RUN: counter decrements each edge. On the edge where it reaches zero, HI/LO are written and the state returns to IDLE.
- Any `start` while in RUN is ignored entirely, including MTHI/MTLO. The hazard unit must not issue such requests.
- Arithmetic (results formed from the latched operands):
  - MULT: {HI,LO} = signed A × signed B, full 2·WIDTH product.
  - MULTU: {HI,LO} = unsigned A × unsigned B.
  - DIV: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - DIVU: LO = unsigned quotient; HI = unsigned remainder.
  - DIV of most-negative by −1: LO = most-negative value, HI = 0 (no trap).
  - Divisor zero (DIV or DIVU): full latency is still spent; HI and LO are left unchanged.
- The result datapath may be combinational on the latched operands or iterative. Only the cycle-level behaviour below is normative.

## Timing
- Reset values: `busy`=0, `HI`=0, `LO`=0, state IDLE, counter 0. Reset takes priority over a coincident `start`.
- `busy` is registered. For a request sampled at edge E0:
  - `busy`=1 from after E0 until after edge E_N, where N is the op's latency;
  - `busy` is high for exactly N cycles;
  - HI/LO take their new values at E_N, the same edge `busy` falls.
- Back-to-back ops: a new request may be sampled at E_N itself. `busy` is 0 that cycle combinationally from the FSM view, because the FSM is IDLE after E_N. The request is accepted one edge later at the earliest, so there is no overlap.
- MTHI/MTLO: 1-cycle write with no `busy` assertion.
- Reset mid-RUN: the in-flight op is discarded. After the reset edge, `busy`=0 and HI=LO=0.
- Operand changes on A/B/op during RUN have no effect.

## Test plan
- Use WIDTH=32, MULT_CYCLES=5, DIV_CYCLES=10.
- Multiply:
  - MULT A=0xFFFFFFFF, B=0x00000002 → `busy` high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFE.
  - MULTU with the same operands → HI=0x00000001, LO=0xFFFFFFFE.
- Divide:
  - DIV A=0xFFFFFFF9 (−7), B=2 → after 10 cycles LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU A=7, B=2 → LO=3, HI=1.
  - DIV A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- Divide-by-zero: MTHI 0x11, then MTLO 0x22 (each visible next cycle, `busy` stays 0). Then DIV A=5, B=0 → `busy` high for 10 cycles; HI=0x11 and LO=0x22 afterwards.
- Ignore-while-busy:
  - MULTU 3×4 is started.
  - 2 cycles later, DIVU 100/7 and MTLO 0xDEAD are pulsed with `start`.
  - Required: after 5 cycles HI=0, LO=12; `busy` falls and does not re-rise.
- Reset mid-op: after MTLO 0x55, DIV 9/3 is started. `reset` is pulsed at its 4th busy cycle, with `start`+MTHI 0x77 held in the same cycle → `busy`=0, HI=0, LO=0 after the reset edge. No later result write.

Source files
------------

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// o_busy covers the whole latency of MULT*/DIV*; MTHI/MTLO write in one cycle.
module mult_div_unit #(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [2:0]       i_op,
  input  logic             i_start,
  output logic             o_busy,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [WIDTH-1:0] W_ZERO   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] W_ONE    = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MULT = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_DIV  = CNT_W'(DIV_CYCLES);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [2:0]       r_op;
  logic             r_busy;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic             w_res_we;
  logic [WIDTH-1:0] w_res_hi;
  logic [WIDTH-1:0] w_res_lo;

  // Full-width product; sign extension to 2*WIDTH makes the truncated product exact.
  function automatic logic [2*WIDTH-1:0] f_mul(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sgn);
    logic [2*WIDTH-1:0] ext_a;
    logic [2*WIDTH-1:0] ext_b;
    ext_a = {{WIDTH{sgn & a[WIDTH-1]}}, a};
    ext_b = {{WIDTH{sgn & b[WIDTH-1]}}, b};
    return ext_a * ext_b;
  endfunction

  // Returns {remainder, quotient}; quotient truncates toward zero, remainder follows the dividend.
  function automatic logic [2*WIDTH-1:0] f_div(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic             sgn);
    logic             neg_a;
    logic             neg_b;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] quo;
    logic [WIDTH-1:0] rem;
    neg_a = sgn & a[WIDTH-1];
    neg_b = sgn & b[WIDTH-1];
    mag_a = neg_a ? (~a + W_ONE) : a;
    mag_b = neg_b ? (~b + W_ONE) : b;
    mag_b = (mag_b == W_ZERO) ? W_ONE : mag_b;
    quo   = mag_a / mag_b;
    rem   = mag_a % mag_b;
    quo   = (neg_a ^ neg_b) ? (~quo + W_ONE) : quo;
    rem   = neg_a ? (~rem + W_ONE) : rem;
    return {rem, quo};
  endfunction

  // Result formed from the latched operands; a zero divisor suppresses the write.
  always_comb begin
    w_res_we = 1'b0;
    w_res_hi = r_hi;
    w_res_lo = r_lo;
    case (r_op)
      OP_MULT: begin
        w_res_we             = 1'b1;
        {w_res_hi, w_res_lo} = f_mul(r_a, r_b, 1'b1);
      end
      OP_MULTU: begin
        w_res_we             = 1'b1;
        {w_res_hi, w_res_lo} = f_mul(r_a, r_b, 1'b0);
      end
      OP_DIV, OP_DIVU: begin
        if (r_b != W_ZERO) begin
          w_res_we             = 1'b1;
          {w_res_hi, w_res_lo} = f_div(r_a, r_b, (r_op == OP_DIV));
        end else begin
          w_res_we = 1'b0;
        end
      end
      default: begin
        w_res_we = 1'b0;
      end
    endcase
  end

  // Control FSM, latency counter, operand latches and HI/LO.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= CNT_ZERO;
      r_a     <= W_ZERO;
      r_b     <= W_ZERO;
      r_op    <= 3'd0;
      r_busy  <= 1'b0;
      r_hi    <= W_ZERO;
      r_lo    <= W_ZERO;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_start) begin
            case (i_op)
              OP_MULT, OP_MULTU: begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_op    <= i_op;
                r_cnt   <= CNT_MULT;
                r_busy  <= 1'b1;
                r_state <= ST_RUN;
              end
              OP_DIV, OP_DIVU: begin
                r_a     <= i_a;
                r_b     <= i_b;
                r_op    <= i_op;
                r_cnt   <= CNT_DIV;
                r_busy  <= 1'b1;
                r_state <= ST_RUN;
              end
              OP_MTHI: r_hi <= i_a;
              OP_MTLO: r_lo <= i_a;
              default: r_state <= ST_IDLE;
            endcase
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_RUN: begin
          // Requests arriving here are dropped; the hazard unit must hold them off.
          if ((r_cnt == CNT_ONE) || (r_cnt == CNT_ZERO)) begin
            if (w_res_we) begin
              r_hi <= w_res_hi;
              r_lo <= w_res_lo;
            end else begin
              r_hi <= r_hi;
            end
            r_cnt   <= CNT_ZERO;
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_ONE;
          end
        end
        default: begin
          r_cnt   <= CNT_ZERO;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = r_busy;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed vector table, hand-built
// corner sequences and randomized ops against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk;
  logic        reset;
  logic [31:0] a_s;
  logic [31:0] b_s;
  logic [2:0]  op_s;
  logic        start;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_hi;
  logic [31:0] m_lo;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  mult_div_unit #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .i_clk   (clk),
    .i_reset (reset),
    .i_a     (a_s),
    .i_b     (b_s),
    .i_op    (op_s),
    .i_start (start),
    .o_busy  (busy),
    .o_hi    (hi),
    .o_lo    (lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic int lat_of(input logic [2:0] op);
    if (op >= 3'd1 && op <= 3'd2) return 5;
    if (op >= 3'd3 && op <= 3'd4) return 10;
    return 0;
  endfunction

  // Reference model: HI/LO after the op, from plain 64-bit arithmetic.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      q;
    longint      r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd1: begin p = 64'(sa * sb); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd2: begin p = 64'(a) * 64'(b); m_hi = p[63:32]; m_lo = p[31:0]; end
      3'd3: if (b != 32'd0) begin q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0]; end
      3'd4: if (b != 32'd0) begin m_lo = a / b; m_hi = a % b; end
      3'd5: m_hi = a;
      3'd6: m_lo = a;
      default: ;
    endcase
  endtask

  // Issue one request, scramble the inputs while it runs, then check latency and result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int exp_lat, input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input string name);
    int n;
    start = 1'b1;
    op_s  = op;
    a_s   = a;
    b_s   = b;
    @(posedge clk); #1;
    start = 1'b0;
    op_s  = 3'($urandom);
    a_s   = $urandom;
    b_s   = $urandom;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
      a_s = $urandom;
      b_s = $urandom;
    end
    check({name, " latency"}, 64'(n), 64'(exp_lat));
    check({name, " HI"}, 64'(hi), 64'(exp_hi));
    check({name, " LO"}, 64'(lo), 64'(exp_lo));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int bad;
    logic [2:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    vecs[0] = '{3'd1, 32'hFFFFFFFF, 32'h00000002, 5,  32'hFFFFFFFF, 32'hFFFFFFFE};
    vecs[1] = '{3'd2, 32'hFFFFFFFF, 32'h00000002, 5,  32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{3'd3, 32'hFFFFFFF9, 32'h00000002, 10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{3'd4, 32'h00000007, 32'h00000002, 10, 32'h00000001, 32'h00000003};
    vecs[4] = '{3'd3, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000};
    vecs[5] = '{3'd5, 32'h00000011, 32'h00000000, 0,  32'h00000011, 32'h80000000};
    vecs[6] = '{3'd6, 32'h00000022, 32'h00000000, 0,  32'h00000011, 32'h00000022};
    vecs[7] = '{3'd3, 32'h00000005, 32'h00000000, 10, 32'h00000011, 32'h00000022};
    vecs[8] = '{3'd4, 32'h12345678, 32'h00000000, 10, 32'h00000011, 32'h00000022};
    vecs[9] = '{3'd7, 32'h99999999, 32'h00000001, 0,  32'h00000011, 32'h00000022};

    // Reset wins over a coincident MTHI.
    reset = 1'b1;
    start = 1'b1;
    op_s  = 3'd5;
    a_s   = 32'h00000ABC;
    b_s   = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'd0);
    check("reset HI", 64'(hi), 64'd0);
    check("reset LO", 64'(lo), 64'd0);
    reset = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hi, vecs[i].lo,
             $sformatf("vec%0d", i));
    end

    // Requests during RUN are ignored, including MTLO.
    start = 1'b1; op_s = 3'd2; a_s = 32'd3; b_s = 32'd4;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    start = 1'b1; op_s = 3'd4; a_s = 32'd100; b_s = 32'd7;
    @(posedge clk); #1;
    op_s = 3'd6; a_s = 32'h0000DEAD;
    @(posedge clk); #1;
    start = 1'b0;
    n = 3;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("ignore latency", 64'(n), 64'd5);
    check("ignore HI", 64'(hi), 64'd0);
    check("ignore LO", 64'(lo), 64'd12);
    bad = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd12) bad++;
    end
    check("ignore no rerise", 64'(bad), 64'd0);

    // Reset in the 4th busy cycle of a DIV, with MTHI held alongside.
    run_op(3'd6, 32'h55, 32'h0, 0, 32'd0, 32'h55, "mtlo55");
    start = 1'b1; op_s = 3'd3; a_s = 32'd9; b_s = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("pre-reset busy", 64'(busy), 64'd1);
    reset = 1'b1; start = 1'b1; op_s = 3'd5; a_s = 32'h77;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0;
    check("midrun reset busy", 64'(busy), 64'd0);
    check("midrun reset HI", 64'(hi), 64'd0);
    check("midrun reset LO", 64'(lo), 64'd0);
    bad = 0;
    repeat (15) begin
      @(posedge clk); #1;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
    end
    check("midrun no late write", 64'(bad), 64'd0);

    // Randomized ops against the reference model.
    m_hi = 32'd0;
    m_lo = 32'd0;
    for (int i = 0; i < 60; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h80000000; rb = 32'hFFFFFFFF; end
        2: rb = 32'($urandom_range(1, 15));
        3: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 3));
        default: ;
      endcase
      model(rop, ra, rb);
      run_op(rop, ra, rb, lat_of(rop), m_hi, m_lo, $sformatf("rand%0d op%0d", i, rop));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
